bus_intercon: RTL and testbench

- Parametrised successor to the single-slave register interconnect.
- Sits between the AXI3 GP0 bridge's simple request/ack master port and NSLV register-style slaves, e.g. regs, DMA and video control blocks.
- Decodes the address against per-slave base windows and forwards one transaction at a time.
- Returns a decode error for unmapped addresses and a timeout error for slaves that never acknowledge.

---
 rtl/bus_intercon.sv | 187 ++++++++++++++++++
 tb/tb_bus_intercon.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_intercon.sv
// Address-decoding request/ack interconnect: one master, NSLV register slaves, decode/timeout errors.
// Define BUS_INTERCON_STATS_EN to add the err_count/err_addr error statistics outputs.
module bus_intercon #(
    parameter int unsigned        NSLV     = 4,
    parameter int unsigned        SLV_AW   = 12,
    parameter logic [NSLV*32-1:0] BASE     = {32'h3000, 32'h2000, 32'h1000, 32'h0},
    parameter int unsigned        TIMEOUT  = 255,
    parameter logic [31:0]        ERR_DATA = 32'hDEADBEEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 m_req,
    input  logic                 m_wr,
    input  logic [31:0]          m_addr,
    input  logic [3:0]           m_wstrb,
    input  logic [31:0]          m_wdata,
    output logic                 m_ack,
    output logic                 m_err,
    output logic [31:0]          m_rdata,
    output logic [NSLV-1:0]      s_req,
    input  logic [NSLV-1:0]      s_ack,
    input  logic [NSLV*32-1:0]   s_rdata,
    output logic [31:0]          s_addr,
    output logic                 s_wr,
    output logic [3:0]           s_wstrb,
    output logic [31:0]          s_wdata
`ifdef BUS_INTERCON_STATS_EN
    ,
    output logic [15:0]          err_count,
    output logic [31:0]          err_addr
`endif
);

    if (NSLV < 1 || NSLV > 16 || SLV_AW > 29) begin : g_param_check
        $fatal(1, "bus_intercon: NSLV must be 1..16 and SLV_AW at most 29");
    end

    localparam int unsigned IW = (NSLV > 1) ? $clog2(NSLV) : 1;
    localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int unsigned TW = 30 - SLV_AW;
    localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e          state_q, state_d;
    logic            m_ack_q, m_ack_d;
    logic            m_err_q, m_err_d;
    logic [31:0]     m_rdata_q, m_rdata_d;
    logic [NSLV-1:0] s_req_q, s_req_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [IW-1:0]   sel_q, sel_d;

    logic            dec_hit;
    logic [IW-1:0]   dec_idx;
    logic            sel_ack;
    logic [31:0]     sel_rdata;

    // Scan from the top so the lowest matching window is the one left standing.
    always_comb begin
        dec_hit = 1'b0;
        dec_idx = '0;
        for (int i = int'(NSLV) - 1; i >= 0; i--) begin
            if (m_addr[29:SLV_AW] == BASE[i*32+SLV_AW +: TW]) begin
                dec_hit = 1'b1;
                dec_idx = IW'(i);
            end
        end
    end

    always_comb begin
        sel_ack   = 1'b0;
        sel_rdata = '0;
        for (int i = 0; i < int'(NSLV); i++) begin
            if (sel_q == IW'(i)) begin
                sel_ack   = s_ack[i];
                sel_rdata = s_rdata[i*32 +: 32];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        m_ack_d   = 1'b0;
        m_err_d   = m_err_q;
        m_rdata_d = m_rdata_q;
        s_req_d   = '0;
        cnt_d     = cnt_q;
        sel_d     = sel_q;
        case (state_q)
            StIdle: begin
                if (m_req) begin
                    if (dec_hit) begin
                        s_req_d[dec_idx] = 1'b1;
                        sel_d            = dec_idx;
                        cnt_d            = '0;
                        state_d          = StWait;
                    end else begin
                        state_d = StResp;
                    end
                end
            end
            StWait: begin
                if (sel_ack) begin
                    m_ack_d   = 1'b1;
                    m_err_d   = 1'b0;
                    m_rdata_d = sel_rdata;
                    state_d   = StIdle;
                end else if (TIMEOUT != 0 && cnt_q == CNT_LAST) begin
                    m_ack_d   = 1'b1;
                    m_err_d   = 1'b1;
                    m_rdata_d = ERR_DATA;
                    state_d   = StIdle;
                end else if (cnt_q != '1) begin
                    // Saturate so a disabled timeout never wraps the counter.
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StResp: begin
                m_ack_d   = 1'b1;
                m_err_d   = 1'b1;
                m_rdata_d = ERR_DATA;
                state_d   = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            m_ack_q   <= 1'b0;
            m_err_q   <= 1'b0;
            m_rdata_q <= '0;
            s_req_q   <= '0;
            cnt_q     <= '0;
            sel_q     <= '0;
        end else begin
            state_q   <= state_d;
            m_ack_q   <= m_ack_d;
            m_err_q   <= m_err_d;
            m_rdata_q <= m_rdata_d;
            s_req_q   <= s_req_d;
            cnt_q     <= cnt_d;
            sel_q     <= sel_d;
        end
    end

    assign m_ack   = m_ack_q;
    assign m_err   = m_err_q;
    assign m_rdata = m_rdata_q;
    assign s_req   = s_req_q;
    assign s_addr  = m_addr;
    assign s_wr    = m_wr;
    assign s_wstrb = m_wstrb;
    assign s_wdata = m_wdata;

`ifdef BUS_INTERCON_STATS_EN
    logic [15:0] err_cnt_q, err_cnt_d;
    logic [31:0] err_addr_q, err_addr_d;

    // m_addr is still held by the master on the edge that raises the error m_ack.
    always_comb begin
        err_cnt_d  = err_cnt_q;
        err_addr_d = err_addr_q;
        if (m_ack_d && m_err_d) begin
            if (err_cnt_q != 16'hFFFF) begin
                err_cnt_d = err_cnt_q + 16'd1;
            end
            err_addr_d = m_addr;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt_q  <= '0;
            err_addr_q <= '0;
        end else begin
            err_cnt_q  <= err_cnt_d;
            err_addr_q <= err_addr_d;
        end
    end

    assign err_count = err_cnt_q;
    assign err_addr  = err_addr_q;
`endif

endmodule

// File: tb/tb_bus_intercon.sv
// Self-checking bench for bus_intercon: directed and randomized transactions against a window model.
// Slave 3 deliberately overlaps slave 1 so lowest-index priority is exercised.
module tb_bus_intercon;

    localparam int NSLV = 4;
    localparam int TO   = 8;
    localparam logic [NSLV*32-1:0] BASE_P = {32'h1000, 32'h2000, 32'h1000, 32'h0000};

    logic              clk, rst;
    logic              m_req, m_wr;
    logic [31:0]       m_addr, m_wdata;
    logic [3:0]        m_wstrb;
    logic              m_ack, m_err;
    logic [31:0]       m_rdata;
    logic [NSLV-1:0]   s_req, s_ack;
    logic [NSLV*32-1:0] s_rdata;
    logic [31:0]       s_addr, s_wdata;
    logic              s_wr;
    logic [3:0]        s_wstrb;
`ifdef BUS_INTERCON_STATS_EN
    logic [15:0]       err_count;
    logic [31:0]       err_addr;
`endif

    int checks = 0;
    int errors = 0;

    // Independent window table: index i is slave i.
    logic [31:0] base_tbl [NSLV] = '{32'h0000, 32'h1000, 32'h2000, 32'h1000};

    bus_intercon #(
        .NSLV    (NSLV),
        .SLV_AW  (12),
        .BASE    (BASE_P),
        .TIMEOUT (TO),
        .ERR_DATA(32'hDEADBEEF)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .m_req  (m_req),
        .m_wr   (m_wr),
        .m_addr (m_addr),
        .m_wstrb(m_wstrb),
        .m_wdata(m_wdata),
        .m_ack  (m_ack),
        .m_err  (m_err),
        .m_rdata(m_rdata),
        .s_req  (s_req),
        .s_ack  (s_ack),
        .s_rdata(s_rdata),
        .s_addr (s_addr),
        .s_wr   (s_wr),
        .s_wstrb(s_wstrb),
        .s_wdata(s_wdata)
`ifdef BUS_INTERCON_STATS_EN
        ,
        .err_count(err_count),
        .err_addr (err_addr)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int exp_slave(input logic [31:0] a);
        for (int i = 0; i < NSLV; i++) begin
            if ((a & 32'h3FFF_F000) == (base_tbl[i] & 32'h3FFF_F000)) return i;
        end
        return -1;
    endfunction

    // Drives one transaction from a negedge; the slave acks `delay` cycles after s_req (-1: never).
    // Cycle 0 is the cycle m_req is first presented; lat is the cycle m_ack is seen (-1: none).
    task automatic run_txn(input logic wr, input logic [31:0] addr, input logic [3:0] strb,
                           input logic [31:0] wd, input int delay, input logic [31:0] rd,
                           output int lat, output logic err, output logic [31:0] rdata,
                           output logic [3:0] sreq_or, output int sreq_cnt, output int pass_bad);
        int sreq_at;
        int k;
        lat = -1; err = 1'b0; rdata = '0; sreq_or = '0; sreq_cnt = 0; pass_bad = 0;
        sreq_at = -1; k = -1;
        m_req = 1'b1; m_wr = wr; m_addr = addr; m_wstrb = strb; m_wdata = wd;
        s_ack = '0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (s_addr !== addr || s_wr !== wr || s_wstrb !== strb || s_wdata !== wd)
                pass_bad++;
            if (s_req !== '0) begin
                sreq_or |= s_req;
                sreq_cnt++;
                if (sreq_at < 0) begin
                    sreq_at = c;
                    for (int b = NSLV - 1; b >= 0; b--) if (s_req[b]) k = b;
                end
            end
            if (m_ack === 1'b1) begin
                lat = c; err = m_err; rdata = m_rdata;
                break;
            end
            s_ack   = 4'($urandom);
            s_rdata = {$urandom, $urandom, $urandom, $urandom};
            if (k >= 0) begin
                s_ack[k] = (delay >= 0 && c == sreq_at + delay);
                if (s_ack[k]) s_rdata[k*32 +: 32] = rd;
            end
        end
        m_req = 1'b0;
        s_ack = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        m_req = 1'b0; m_wr = 1'b0; m_addr = '0; m_wstrb = '0; m_wdata = '0;
        s_ack = '0; s_rdata = '0;
        repeat (2) @(negedge clk);
        checks += 4;
        if (m_ack !== 1'b0) begin errors++; $display("FAIL reset_m_ack got %b exp 0", m_ack); end
        if (m_err !== 1'b0) begin errors++; $display("FAIL reset_m_err got %b exp 0", m_err); end
        if (m_rdata !== 32'h0) begin
            errors++; $display("FAIL reset_m_rdata got %h exp 0", m_rdata);
        end
        if (s_req !== 4'b0) begin errors++; $display("FAIL reset_s_req got %b exp 0", s_req); end
`ifdef BUS_INTERCON_STATS_EN
        checks++;
        if (err_count !== 16'h0 || err_addr !== 32'h0) begin
            errors++; $display("FAIL reset_stats got %h/%h exp 0/0", err_count, err_addr);
        end
`endif
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_read();
        int lat, sc, pb;
        logic e;
        logic [31:0] rd;
        logic [3:0] so;
        run_txn(1'b0, 32'h0000_2004, 4'hF, 32'h0, 2, 32'h1234_5678, lat, e, rd, so, sc, pb);
        checks += 5;
        if (so !== 4'b0100) begin errors++; $display("FAIL read_s_req got %b exp 0100", so); end
        if (sc !== 1) begin errors++; $display("FAIL read_s_req_cycles got %0d exp 1", sc); end
        if (lat !== 4) begin errors++; $display("FAIL read_latency got %0d exp 4", lat); end
        if (e !== 1'b0) begin errors++; $display("FAIL read_m_err got %b exp 0", e); end
        if (rd !== 32'h1234_5678) begin
            errors++; $display("FAIL read_m_rdata got %h exp 12345678", rd);
        end
    endtask

    task automatic test_write();
        int lat, sc, pb;
        logic e;
        logic [31:0] rd;
        logic [3:0] so;
        run_txn(1'b1, 32'h0000_0010, 4'b0011, 32'hA5A5_A5A5, 3, 32'h0, lat, e, rd, so, sc, pb);
        checks += 4;
        if (so !== 4'b0001) begin errors++; $display("FAIL write_s_req got %b exp 0001", so); end
        if (pb !== 0) begin errors++; $display("FAIL write_passthru got %0d bad exp 0", pb); end
        if (lat !== 5) begin errors++; $display("FAIL write_latency got %0d exp 5", lat); end
        if (e !== 1'b0) begin errors++; $display("FAIL write_m_err got %b exp 0", e); end
    endtask

    task automatic test_decode_err();
        logic [31:0] addrs [3] = '{32'h0000_8000, 32'h0000_3004, 32'h4000_9FFC};
        int lat, sc, pb;
        logic e;
        logic [31:0] rd;
        logic [3:0] so;
        foreach (addrs[i]) begin
            run_txn(1'b0, addrs[i], 4'hF, 32'h0, 1, 32'h0, lat, e, rd, so, sc, pb);
            checks += 4;
            if (so !== 4'b0) begin errors++; $display("FAIL decerr_s_req got %b exp 0", so); end
            if (lat !== 2) begin errors++; $display("FAIL decerr_latency got %0d exp 2", lat); end
            if (e !== 1'b1) begin errors++; $display("FAIL decerr_m_err got %b exp 1", e); end
            if (rd !== 32'hDEAD_BEEF) begin
                errors++; $display("FAIL decerr_m_rdata got %h exp deadbeef", rd);
            end
        end
    endtask

    task automatic test_overlap();
        int lat, sc, pb;
        logic e;
        logic [31:0] rd;
        logic [3:0] so;
        run_txn(1'b0, 32'h8000_1ABC, 4'hF, 32'h0, 1, 32'h0BAD_CAFE, lat, e, rd, so, sc, pb);
        checks += 2;
        if (so !== 4'b0010) begin errors++; $display("FAIL overlap_s_req got %b exp 0010", so); end
        if (rd !== 32'h0BAD_CAFE) begin
            errors++; $display("FAIL overlap_m_rdata got %h exp 0badcafe", rd);
        end
    endtask

    task automatic test_timeout();
        int lat, sc, pb, acks;
        logic e;
        logic [31:0] rd;
        logic [3:0] so;
        run_txn(1'b0, 32'h0000_1000, 4'hF, 32'h0, -1, 32'h0, lat, e, rd, so, sc, pb);
        checks += 3;
        if (lat !== TO + 1) begin
            errors++; $display("FAIL timeout_latency got %0d exp %0d", lat, TO + 1);
        end
        if (e !== 1'b1) begin errors++; $display("FAIL timeout_m_err got %b exp 1", e); end
        if (rd !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL timeout_m_rdata got %h exp deadbeef", rd);
        end
        acks = 0;
        s_ack = 4'b0010;
        repeat (5) begin
            @(negedge clk);
            if (m_ack === 1'b1) acks++;
        end
        s_ack = '0;
        checks++;
        if (acks !== 0) begin errors++; $display("FAIL stray_ack got %0d m_ack exp 0", acks); end
        run_txn(1'b0, 32'h0000_1008, 4'hF, 32'h0, 3, 32'h5555_AAAA, lat, e, rd, so, sc, pb);
        checks += 2;
        if (lat !== 5 || e !== 1'b0) begin
            errors++; $display("FAIL after_timeout got lat %0d err %b exp 5 0", lat, e);
        end
        if (rd !== 32'h5555_AAAA) begin
            errors++; $display("FAIL after_timeout_rdata got %h exp 5555aaaa", rd);
        end
    endtask

    task automatic test_ack_at_timeout();
        int lat, sc, pb;
        logic e;
        logic [31:0] rd;
        logic [3:0] so;
        run_txn(1'b0, 32'h0000_2000, 4'hF, 32'h0, TO - 1, 32'hC0DE_0001, lat, e, rd, so, sc, pb);
        checks += 2;
        if (lat !== TO + 1 || e !== 1'b0) begin
            errors++; $display("FAIL ack_at_timeout got lat %0d err %b exp %0d 0", lat, e, TO + 1);
        end
        if (rd !== 32'hC0DE_0001) begin
            errors++; $display("FAIL ack_at_timeout_rdata got %h exp c0de0001", rd);
        end
    endtask

    task automatic test_reset_mid();
        int acks;
        m_req = 1'b1; m_wr = 1'b0; m_addr = 32'h0000_0040; m_wstrb = 4'hF;
        @(negedge clk);
        checks++;
        if (s_req !== 4'b0001) begin errors++; $display("FAIL mid_s_req got %b exp 0001", s_req); end
        rst = 1'b1;
        #1;
        checks++;
        if (s_req !== 4'b0 || m_ack !== 1'b0 || m_err !== 1'b0 || m_rdata !== 32'h0) begin
            errors++;
            $display("FAIL mid_reset_outputs got req %b ack %b err %b rdata %h exp all 0",
                     s_req, m_ack, m_err, m_rdata);
        end
        m_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        s_ack = 4'b1111;
        acks = 0;
        repeat (10) begin
            @(negedge clk);
            if (m_ack === 1'b1) acks++;
        end
        s_ack = '0;
        checks++;
        if (acks !== 0) begin errors++; $display("FAIL mid_reset_ack got %0d exp 0", acks); end
    endtask

    task automatic test_random();
        logic [31:0] wins [5] = '{32'h0000, 32'h1000, 32'h2000, 32'h3000, 32'h8000};
        int lat, sc, pb, delay, es, x_lat, x_sc;
        logic e, x_e;
        logic [31:0] rd, addr, srd, x_rd;
        logic [3:0] so, x_so;
        for (int n = 0; n < 40; n++) begin
            addr = wins[$urandom_range(0, 4)] | 32'($urandom_range(0, 4095))
                   | {2'($urandom), 30'h0};
            delay = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 10));
            srd = $urandom;
            es = exp_slave(addr);
            if (es < 0) begin
                x_lat = 2; x_e = 1'b1; x_rd = 32'hDEAD_BEEF; x_so = 4'b0; x_sc = 0;
            end else if (delay >= 0 && delay < TO) begin
                x_lat = delay + 2; x_e = 1'b0; x_rd = srd; x_so = 4'(1 << es); x_sc = 1;
            end else begin
                x_lat = TO + 1; x_e = 1'b1; x_rd = 32'hDEAD_BEEF; x_so = 4'(1 << es); x_sc = 1;
            end
            run_txn(1'($urandom), addr, 4'($urandom), $urandom, delay, srd,
                    lat, e, rd, so, sc, pb);
            checks++;
            if (lat !== x_lat || e !== x_e || rd !== x_rd || so !== x_so || sc !== x_sc
                || pb !== 0) begin
                errors++;
                $display("FAIL rand_txn addr %h delay %0d got lat %0d err %b rd %h req %b/%0d pb %0d exp lat %0d err %b rd %h req %b/%0d",
                         addr, delay, lat, e, rd, so, sc, pb, x_lat, x_e, x_rd, x_so, x_sc);
            end
            @(negedge clk);
            checks++;
            if (m_ack !== 1'b0 || m_err !== x_e || m_rdata !== x_rd) begin
                errors++;
                $display("FAIL rand_hold got ack %b err %b rd %h exp ack 0 err %b rd %h",
                         m_ack, m_err, m_rdata, x_e, x_rd);
            end
        end
    endtask

`ifdef BUS_INTERCON_STATS_EN
    task automatic test_stats();
        logic [31:0] addrs [3] = '{32'h0000_8000, 32'h0000_3004, 32'hC000_9ABC};
        int lat, sc, pb;
        logic e;
        logic [31:0] rd;
        logic [3:0] so;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        foreach (addrs[i]) run_txn(1'b0, addrs[i], 4'hF, 32'h0, 1, 32'h0, lat, e, rd, so, sc, pb);
        run_txn(1'b0, 32'h0000_2000, 4'hF, 32'h0, 1, 32'h1, lat, e, rd, so, sc, pb);
        checks += 2;
        if (err_count !== 16'd3) begin
            errors++; $display("FAIL stats_count got %0d exp 3", err_count);
        end
        if (err_addr !== 32'hC000_9ABC) begin
            errors++; $display("FAIL stats_addr got %h exp c0009abc", err_addr);
        end
        force dut.err_cnt_q = 16'hFFFF;
        @(negedge clk);
        release dut.err_cnt_q;
        @(negedge clk);
        run_txn(1'b0, 32'h0000_F000, 4'hF, 32'h0, 1, 32'h0, lat, e, rd, so, sc, pb);
        checks += 2;
        if (err_count !== 16'hFFFF) begin
            errors++; $display("FAIL stats_saturate got %h exp ffff", err_count);
        end
        if (err_addr !== 32'h0000_F000) begin
            errors++; $display("FAIL stats_addr_sat got %h exp 0000f000", err_addr);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_read();
        test_write();
        test_decode_err();
        test_overlap();
        test_timeout();
        test_ack_at_timeout();
        test_random();
        test_reset_mid();
`ifdef BUS_INTERCON_STATS_EN
        test_stats();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
